// File: rtl/dco_pkg.sv
// dco_pkg: default DCO parameters and the increment saturation helper shared by the DCO files
package dco_pkg;
  localparam int ACC_W_DEF = 24;
  localparam int BASE_INC_DEF = 1 << 20;
  localparam int COARSE_GAIN_DEF = 1 << 16;
  localparam int FINE_GAIN_DEF = 1 << 8;
  function automatic logic [31:0] sat_inc(input logic [31:0] raw, input logic [31:0] lim);
    return raw > lim ? lim : raw;
  endfunction
endpackage

// File: rtl/dco_if.sv
// dco_if: tuning words and enable in from the loop filter, clk_dco/dco_tick out to the TDC and divider
interface dco_if;
  logic [7:0] CTW;
  logic [7:0] FTW;
  logic enable;
  logic clk_dco;
  logic dco_tick;
  modport master (output CTW, output FTW, output enable, input clk_dco, input dco_tick);
  modport slave (input CTW, input FTW, input enable, output clk_dco, output dco_tick);
endinterface

// File: rtl/dco_inc_calc.sv
// dco_inc_calc: combinational increment from ctw/ftw, saturated so both clk_dco phases last at least one clk (in: ctw, ftw; out: inc)
module dco_inc_calc
  import dco_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int BASE_INC = BASE_INC_DEF,
  parameter int COARSE_GAIN = COARSE_GAIN_DEF,
  parameter int FINE_GAIN = FINE_GAIN_DEF
) (
  input  logic [7:0]       ctw,
  input  logic [7:0]       ftw,
  output logic [ACC_W-1:0] inc
);
  localparam int W = ACC_W + 2;
  localparam logic [31:0] LIM = 32'((64'(1) << (ACC_W - 1)) - 64'(1));
  logic [W-1:0] raw;
  always_comb begin
    raw = W'(BASE_INC) + W'(ctw) * W'(COARSE_GAIN) + W'(ftw) * W'(FINE_GAIN);
    inc = ACC_W'(sat_inc(32'(raw), LIM));
  end
endmodule

// File: rtl/dco.sv
// dco: phase-accumulator oscillator (in: clk, rst_n, bus.CTW/FTW/enable; out: bus.clk_dco = acc MSB, bus.dco_tick on its rise)
module dco
  import dco_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int BASE_INC = BASE_INC_DEF,
  parameter int COARSE_GAIN = COARSE_GAIN_DEF,
  parameter int FINE_GAIN = FINE_GAIN_DEF
) (
  input logic  clk,
  input logic  rst_n,
  dco_if.slave bus
);
  logic [ACC_W-1:0] inc, inc_d, inc_q, acc_d, acc_q;
  logic [ACC_W:0] sum;
  logic tick_d, tick_q;
  dco_inc_calc #(
    .ACC_W(ACC_W), .BASE_INC(BASE_INC), .COARSE_GAIN(COARSE_GAIN), .FINE_GAIN(FINE_GAIN)
  ) u_inc_calc (
    .ctw(bus.CTW),
    .ftw(bus.FTW),
    .inc(inc)
  );
  // sum's carry marks a period boundary; retuning only there keeps periods free of runts
  always_comb begin
    sum = {1'b0, acc_q} + {1'b0, inc_q};
    inc_d = (!bus.enable || sum[ACC_W]) ? inc : inc_q;
    acc_d = bus.enable ? sum[ACC_W-1:0] : '0;
    tick_d = acc_d[ACC_W-1] & ~acc_q[ACC_W-1];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inc_q <= ACC_W'(BASE_INC);
      acc_q <= '0;
      tick_q <= 1'b0;
    end else begin
      inc_q <= inc_d;
      acc_q <= acc_d;
      tick_q <= tick_d;
    end
  end
  assign bus.clk_dco = acc_q[ACC_W-1];
  assign bus.dco_tick = tick_q;
endmodule

// File: tb/tb_dco.sv
// tb_dco: directed self-checking bench for dco, measuring clk_dco periods between dco_tick pulses
module tb_dco;
  logic clk = 1'b0;
  logic rst_n;
  int errors = 0;
  int checks = 0;
  dco_if bus();
  dco dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic wait_tick(output int n, output int highs);
    n = 0;
    highs = 0;
    while (1) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (bus.clk_dco) highs++;
      if (bus.dco_tick) break;
      if (n >= 100) begin
        n = -1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.enable = 1'b0;
    bus.CTW = 8'd0;
    bus.FTW = 8'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.clk_dco !== 1'b0 || bus.dco_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: clk_dco=%b dco_tick=%b want 0 0", bus.clk_dco, bus.dco_tick);
    end
    checks++;
    if (dut.inc_q !== 24'h100000 || dut.acc_q !== 24'h0) begin
      errors++;
      $display("FAIL reset_state: inc_q=%h acc_q=%h want 100000 000000", dut.inc_q, dut.acc_q);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_base();
    int n, h;
    bus.enable = 1'b1;
    wait_tick(n, h);
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL base_first_rise: got %0d cycles want 8", n);
    end
    for (int i = 0; i < 3; i++) begin
      wait_tick(n, h);
      checks++;
      if (n !== 16 || h !== 8) begin
        errors++;
        $display("FAIL base_period: got %0d cycles %0d high want 16 8", n, h);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n, h;
    int exp_p [7] = '{12, 8, 8, 6, 4, 6, 8};
    bus.CTW = 8'd16;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) bus.CTW = 8'd48;
      if (i == 5) begin
        bus.CTW = 8'd0;
        @(negedge clk);
        bus.CTW = 8'd16;
        wait_tick(n, h);
        n++;
      end else begin
        wait_tick(n, h);
      end
      checks++;
      if (n !== exp_p[i]) begin
        errors++;
        $display("FAIL retune_period[%0d]: got %0d cycles want %0d", i, n, exp_p[i]);
      end
    end
  endtask

  task automatic test_fine();
    int n, h;
    int total = 0;
    bus.CTW = 8'd8;
    bus.FTW = 8'd128;
    wait_tick(n, h);
    for (int i = 0; i < 1000; i++) begin
      wait_tick(n, h);
      total += n;
      checks++;
      if (n != 10 && n != 11) begin
        errors++;
        $display("FAIL fine_period[%0d]: got %0d cycles want 10 or 11", i, n);
      end
    end
    checks++;
    if (total < 10448 || total > 10450) begin
      errors++;
      $display("FAIL fine_mean: got %0d cycles per 1000 periods want 10448..10450", total);
    end
  endtask

  task automatic test_saturate();
    int n, h;
    bus.CTW = 8'd255;
    bus.FTW = 8'd255;
    wait_tick(n, h);
    checks++;
    if (dut.inc_q !== 24'h7fffff) begin
      errors++;
      $display("FAIL sat_inc: got %h want 7fffff", dut.inc_q);
    end
    for (int i = 0; i < 50; i++) begin
      wait_tick(n, h);
      checks++;
      if ((n != 2 && n != 3) || h < 1 || h > n - 1) begin
        errors++;
        $display("FAIL sat_period[%0d]: got %0d cycles %0d high want 2..3 with both phases", i, n, h);
      end
    end
  endtask

  task automatic test_disable();
    int n, h;
    bus.enable = 1'b0;
    bus.CTW = 8'd0;
    bus.FTW = 8'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.clk_dco !== 1'b0 || bus.dco_tick !== 1'b0 || dut.acc_q !== 24'h0) begin
        errors++;
        $display("FAIL disable[%0d]: clk_dco=%b tick=%b acc=%h want 0 0 0", i, bus.clk_dco, bus.dco_tick, dut.acc_q);
      end
    end
    checks++;
    if (dut.inc_q !== 24'h100000) begin
      errors++;
      $display("FAIL disable_inc: got %h want 100000", dut.inc_q);
    end
    bus.enable = 1'b1;
    wait_tick(n, h);
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL reenable_rise: got %0d cycles want 8", n);
    end
  endtask

  task automatic test_midrun_reset();
    int n, h;
    bus.enable = 1'b0;
    bus.CTW = 8'd16;
    @(negedge clk);
    bus.enable = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (bus.clk_dco !== 1'b1) begin
      errors++;
      $display("FAIL prereset_high: clk_dco=%b want 1", bus.clk_dco);
    end
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.clk_dco !== 1'b0 || bus.dco_tick !== 1'b0 || dut.inc_q !== 24'h100000 || dut.acc_q !== 24'h0) begin
        errors++;
        $display("FAIL midrun_reset[%0d]: clk_dco=%b tick=%b inc=%h acc=%h want 0 0 100000 0", i, bus.clk_dco, bus.dco_tick, dut.inc_q, dut.acc_q);
      end
    end
    rst_n = 1'b1;
    wait_tick(n, h);
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL postreset_rise: got %0d cycles want 8", n);
    end
  endtask

  initial begin
    test_reset();
    test_base();
    test_back_to_back();
    test_fine();
    test_saturate();
    test_disable();
    test_midrun_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
